// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative radix-2 RV32M multiply/divide unit.
// Operands are latched at issue. Multiplies use shift-add and divides use
// restoring shift-subtract, one bit per cycle on magnitudes, with a final
// sign fix-up. Divide-by-zero and signed overflow take a short path.
module muldiv_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            wb_we,
  output logic [4:0]      wb_addr
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        op_reg;
  logic              neg_reg;
  logic              special_reg;
  logic [XLEN-1:0]   spec_val_reg;
  logic [XLEN-1:0]   addend_reg;   // multiplicand for MUL*, divisor for DIV*
  logic [XLEN:0]     hi_reg;       // product high half / partial remainder
  logic [XLEN-1:0]   lo_reg;       // product low half / quotient
  logic [XLEN-1:0]   res_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [4:0]        rd_reg;

  // Issue-time decode: signedness, magnitudes and special-case detection.
  logic            is_div, a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf, neg_issue, accept;
  logic [XLEN-1:0] a_mag, b_mag, spec_val;

  always_comb begin
    is_div   = funct3[2];
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = a_signed & src_a[XLEN-1];
    b_neg    = b_signed & src_b[XLEN-1];
    a_mag    = a_neg ? -src_a : src_a;
    b_mag    = b_neg ? -src_b : src_b;
    div_zero = is_div && (src_b == '0);
    div_ovf  = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
               (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
    // Remainder follows the dividend sign; everything else is the sign product.
    neg_issue = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
    if (div_zero)
      spec_val = funct3[1] ? src_a : '1;
    else
      spec_val = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    accept = start & ~flush;
  end

  // One iteration step for the operation held in op_reg.
  logic [XLEN:0]     mul_sum, div_shift, div_diff, hi_step;
  logic [XLEN-1:0]   lo_step;
  logic              div_ge;

  always_comb begin
    mul_sum   = hi_reg + {1'b0, (lo_reg[0] ? addend_reg : {XLEN{1'b0}})};
    div_shift = {hi_reg[XLEN-1:0], lo_reg[XLEN-1]};
    div_ge    = div_shift >= {1'b0, addend_reg};
    div_diff  = div_shift - {1'b0, addend_reg};
    if (op_reg[2]) begin
      hi_step = div_ge ? div_diff : div_shift;
      lo_step = {lo_reg[XLEN-2:0], div_ge};
    end else begin
      hi_step = {1'b0, mul_sum[XLEN:1]};
      lo_step = {mul_sum[0], lo_reg[XLEN-1:1]};
    end
  end

  // Final sign fix-up and word selection once all steps are done.
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_val;
  logic              last_step;

  always_comb begin
    prod      = {hi_reg[XLEN-1:0], lo_reg};
    prod_fix  = neg_reg ? -prod : prod;
    quo_fix   = neg_reg ? -lo_reg : lo_reg;
    rem_fix   = neg_reg ? -hi_reg[XLEN-1:0] : hi_reg[XLEN-1:0];
    if (op_reg[2])
      final_val = op_reg[1] ? rem_fix : quo_fix;
    else
      final_val = (op_reg == 3'b000) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    last_step = (cnt_reg == CNT_W'(XLEN));
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; flush aborts from any state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = RUN;
      RUN: begin
        if (flush)                         state_next = IDLE;
        else if (special_reg || last_step) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands at issue, iterate in RUN, capture the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_reg       <= '0;
      neg_reg      <= 1'b0;
      special_reg  <= 1'b0;
      spec_val_reg <= '0;
      addend_reg   <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      res_reg      <= '0;
      cnt_reg      <= '0;
      rd_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg       <= funct3;
            neg_reg      <= neg_issue;
            special_reg  <= div_zero | div_ovf;
            spec_val_reg <= spec_val;
            addend_reg   <= is_div ? b_mag : a_mag;
            hi_reg       <= '0;
            lo_reg       <= is_div ? a_mag : b_mag;
            cnt_reg      <= '0;
            rd_reg       <= rd_addr;
          end
        end
        RUN: begin
          if (special_reg) begin
            res_reg <= spec_val_reg;
          end else if (last_step) begin
            res_reg <= final_val;
          end else begin
            hi_reg  <= hi_step;
            lo_reg  <= lo_step;
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: result only visible during the done pulse.
  always_comb begin
    busy    = (state_reg != IDLE);
    done    = (state_reg == DONE);
    result  = done ? res_reg : '0;
    wb_addr = rd_reg;
    wb_we   = done & ~flush & (rd_reg != 5'd0);
  end

endmodule
